// File: rtl/uart_core.sv
// uart_core: full-duplex UART transceiver in a single clock domain.
//
// Frame on the line, LSB first: start (0), DATA_BITS data bits, an optional
// parity bit, then STOP_BITS stop bits (1). The bit period is CLK_HZ/BAUD
// cycles, truncated.
//
// Parameters:
//   CLK_HZ    system clock frequency in Hz
//   BAUD      line rate in bits per second
//   DATA_BITS payload width, 5..9
//   PARITY    0 = none, 1 = even, 2 = odd
//   STOP_BITS 1 or 2
//
// Ports:
//   clk           system clock, all logic on the rising edge
//   rst           synchronous active-high reset
//   tx_data       payload to send, captured when tx_valid && tx_ready
//   tx_valid      producer has a payload
//   tx_ready      transmitter idle and able to accept a payload
//   tx            serial output, idles high
//   rx            serial input, asynchronous to clk
//   rx_data       last received payload, held until the next frame ends
//   rx_valid      one-cycle pulse when a frame completes (even with errors)
//   rx_parity_err parity mismatch on the current rx_data
//   rx_frame_err  first stop bit of the current rx_data was sampled low
module uart_core #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 1,
    parameter int STOP_BITS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);

    localparam int BIT_CYC = CLK_HZ / BAUD;
    localparam int HALF    = BIT_CYC / 2;
    localparam int CW      = $clog2(BIT_CYC + 1);

    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic          HAS_PAR   = (PARITY != 0);
    localparam logic          PAR_INV   = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    state_t                 tx_state, tx_state_next;
    logic [CW-1:0]          tx_cnt, tx_cnt_next;
    logic [3:0]             tx_idx, tx_idx_next;
    logic [DATA_BITS-1:0]   tx_shift, tx_shift_next;
    logic                   tx_par, tx_par_next;
    logic                   tx_next;
    logic                   tx_bit_end;

    assign tx_bit_end = (tx_cnt == BIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx       <= 1'b1;
        end else begin
            tx_state <= tx_state_next;
            tx_cnt   <= tx_cnt_next;
            tx_idx   <= tx_idx_next;
            tx_shift <= tx_shift_next;
            tx_par   <= tx_par_next;
            tx       <= tx_next;
        end
    end

    // The line level is computed alongside the next state so that tx is a
    // flop output: it changes exactly on bit boundaries and never glitches.
    always_comb begin
        tx_state_next = tx_state;
        tx_idx_next   = tx_idx;
        tx_shift_next = tx_shift;
        tx_par_next   = tx_par;
        tx_next       = tx;
        tx_ready      = (tx_state == S_IDLE);
        if (tx_state == S_IDLE || tx_bit_end) begin
            tx_cnt_next = '0;
        end else begin
            tx_cnt_next = tx_cnt + CW'(1);
        end

        case (tx_state)
            S_IDLE: begin
                if (tx_valid) begin
                    tx_state_next = S_START;
                    tx_shift_next = tx_data;
                    tx_par_next   = (^tx_data) ^ PAR_INV;
                    tx_idx_next   = '0;
                    tx_next       = 1'b0;
                end
            end
            S_START: begin
                if (tx_bit_end) begin
                    tx_state_next = S_DATA;
                    tx_idx_next   = '0;
                    tx_next       = tx_shift[0];
                end
            end
            S_DATA: begin
                if (tx_bit_end) begin
                    if (tx_idx == DATA_LAST) begin
                        tx_idx_next = '0;
                        if (HAS_PAR) begin
                            tx_state_next = S_PAR;
                            tx_next       = tx_par;
                        end else begin
                            tx_state_next = S_STOP;
                            tx_next       = 1'b1;
                        end
                    end else begin
                        tx_idx_next   = tx_idx + 4'd1;
                        tx_shift_next = tx_shift >> 1;
                        tx_next       = tx_shift[1];
                    end
                end
            end
            S_PAR: begin
                if (tx_bit_end) begin
                    tx_state_next = S_STOP;
                    tx_idx_next   = '0;
                    tx_next       = 1'b1;
                end
            end
            S_STOP: begin
                if (tx_bit_end) begin
                    if (tx_idx == STOP_LAST) begin
                        tx_state_next = S_IDLE;
                        tx_idx_next   = '0;
                    end else begin
                        tx_idx_next = tx_idx + 4'd1;
                    end
                end
            end
            default: begin
                tx_state_next = S_IDLE;
                tx_next       = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic                   rx_meta, rx_s, rx_prev;
    state_t                 rx_state, rx_state_next;
    logic [CW-1:0]          rx_cnt, rx_cnt_next;
    logic [3:0]             rx_idx, rx_idx_next;
    logic [DATA_BITS-1:0]   rx_shift, rx_shift_next;
    logic                   rx_par, rx_par_next;
    logic [DATA_BITS-1:0]   rx_data_next;
    logic                   rx_valid_next, rx_perr_next, rx_ferr_next;
    logic                   rx_tick;

    // START waits half a bit to land mid-bit; every later sample is a full
    // bit period after the previous one.
    assign rx_tick = (rx_state == S_START) ? (rx_cnt == HALF_LAST)
                                           : (rx_cnt == BIT_LAST);

    // rx_prev lags rx_s by one cycle. A line stuck low keeps both at 0, so a
    // break is not re-detected as a start until the line has been high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta       <= 1'b1;
            rx_s          <= 1'b1;
            rx_prev       <= 1'b1;
            rx_state      <= S_IDLE;
            rx_cnt        <= '0;
            rx_idx        <= '0;
            rx_shift      <= '0;
            rx_par        <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            rx_meta       <= rx;
            rx_s          <= rx_meta;
            rx_prev       <= rx_s;
            rx_state      <= rx_state_next;
            rx_cnt        <= rx_cnt_next;
            rx_idx        <= rx_idx_next;
            rx_shift      <= rx_shift_next;
            rx_par        <= rx_par_next;
            rx_data       <= rx_data_next;
            rx_valid      <= rx_valid_next;
            rx_parity_err <= rx_perr_next;
            rx_frame_err  <= rx_ferr_next;
        end
    end

    always_comb begin
        rx_state_next = rx_state;
        rx_idx_next   = rx_idx;
        rx_shift_next = rx_shift;
        rx_par_next   = rx_par;
        rx_data_next  = rx_data;
        rx_perr_next  = rx_parity_err;
        rx_ferr_next  = rx_frame_err;
        rx_valid_next = 1'b0;
        if (rx_state == S_IDLE || rx_tick) begin
            rx_cnt_next = '0;
        end else begin
            rx_cnt_next = rx_cnt + CW'(1);
        end

        case (rx_state)
            S_IDLE: begin
                if (rx_prev && !rx_s) begin
                    rx_state_next = S_START;
                end
            end
            S_START: begin
                if (rx_tick) begin
                    if (rx_s) begin
                        rx_state_next = S_IDLE;
                    end else begin
                        rx_state_next = S_DATA;
                        rx_idx_next   = '0;
                    end
                end
            end
            S_DATA: begin
                if (rx_tick) begin
                    rx_shift_next = {rx_s, rx_shift[DATA_BITS-1:1]};
                    if (rx_idx == DATA_LAST) begin
                        rx_idx_next   = '0;
                        rx_state_next = HAS_PAR ? S_PAR : S_STOP;
                    end else begin
                        rx_idx_next = rx_idx + 4'd1;
                    end
                end
            end
            S_PAR: begin
                if (rx_tick) begin
                    rx_par_next   = rx_s;
                    rx_state_next = S_STOP;
                end
            end
            S_STOP: begin
                // Only the first stop bit is checked; returning to IDLE here
                // leaves any further stop bits to the start detector.
                if (rx_tick) begin
                    rx_state_next = S_IDLE;
                    rx_valid_next = 1'b1;
                    rx_data_next  = rx_shift;
                    rx_perr_next  = HAS_PAR & ((^rx_shift) ^ rx_par ^ PAR_INV);
                    rx_ferr_next  = !rx_s;
                end
            end
            default: begin
                rx_state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: self-checking bench for uart_core.
//
// Two instances run with a short bit period (16 cycles):
//   dut_a: 8 data bits, even parity, 2 stop bits
//   dut_b: 8 data bits, odd parity, 1 stop bit
// Each rx input is either looped back from its own tx or driven by the bench.
// Expected tx waveforms are built cycle by cycle from the frame format.
module tb_uart_core;

    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD   = 100_000;
    localparam int BC     = CLK_HZ / BAUD;
    localparam int HALF   = BC / 2;
    localparam int NA     = 12;
    localparam int NB     = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] tx_data_a, tx_data_b;
    logic       tx_valid_a, tx_valid_b;
    logic       tx_ready_a, tx_ready_b;
    logic       tx_a, tx_b;
    logic       rx_a, rx_b;
    logic [7:0] rx_data_a, rx_data_b;
    logic       rx_valid_a, rx_valid_b;
    logic       perr_a, perr_b, ferr_a, ferr_b;
    logic       loop_a, loop_b, drv_a, drv_b;

    assign rx_a = loop_a ? tx_a : drv_a;
    assign rx_b = loop_b ? tx_b : drv_b;

    uart_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) dut_a (
        .clk(clk), .rst(rst), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
        .tx_ready(tx_ready_a), .tx(tx_a), .rx(rx_a), .rx_data(rx_data_a),
        .rx_valid(rx_valid_a), .rx_parity_err(perr_a), .rx_frame_err(ferr_a)
    );

    uart_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_b (
        .clk(clk), .rst(rst), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
        .tx_ready(tx_ready_b), .tx(tx_b), .rx(rx_b), .rx_data(rx_data_b),
        .rx_valid(rx_valid_b), .rx_parity_err(perr_b), .rx_frame_err(ferr_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Count rx_valid cycles; a stuck or doubled pulse shows up as extra counts.
    int nv_a = 0, nv_b = 0, last_cyc_a = 0;
    always @(negedge clk) begin
        if (rx_valid_a) begin
            nv_a       <= nv_a + 1;
            last_cyc_a <= cyc;
        end
        if (rx_valid_b) nv_b <= nv_b + 1;
    end

    int compared = 0, mismatched = 0;
    logic exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       exp_par;
        logic [7:0] exp_rx;
    } vec_t;
    vec_t vecs[8];

    initial begin
        repeat (90000) @(posedge clk);
        $display("[TB] FAIL watchdog: cycle limit reached, got %0d compared expected completion", compared);
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference parity: count of ones, even or odd mode.
    function automatic logic model_parity(input logic [7:0] d, input int mode);
        int ones;
        ones = $countones(d);
        return (mode == 1) ? logic'(ones % 2) : logic'(1 - (ones % 2));
    endfunction

    task automatic appendBit(input logic b);
        repeat (BC) exp_q.push_back(b);
    endtask

    task automatic appendFrame(input logic [7:0] d, input logic pbit, input int nstop);
        appendBit(1'b0);
        for (int i = 0; i < 8; i++) appendBit(d[i]);
        appendBit(pbit);
        for (int i = 0; i < nstop; i++) appendBit(1'b1);
    endtask

    function automatic logic get_tx(input int which);
        return (which == 0) ? tx_a : tx_b;
    endfunction

    function automatic logic get_ready(input int which);
        return (which == 0) ? tx_ready_a : tx_ready_b;
    endfunction

    task automatic set_tx(input int which, input logic [7:0] d, input logic v);
        if (which == 0) begin tx_data_a = d; tx_valid_a = v; end
        else begin tx_data_b = d; tx_valid_b = v; end
    endtask

    task automatic set_valid(input int which, input logic v);
        if (which == 0) tx_valid_a = v;
        else tx_valid_b = v;
    endtask

    task automatic set_drv(input int which, input logic v);
        if (which == 0) drv_a = v;
        else drv_b = v;
    endtask

    // Waits (bounded) for tx_ready, presents one payload and returns at the
    // negedge right after the handshake edge.
    task automatic applyStimulus(input int which, input logic [7:0] d, input logic hold);
        int w = 0;
        while (get_ready(which) !== 1'b1 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        checkOutput("tx_ready_before_send", {31'd0, get_ready(which)}, 32'd1);
        set_tx(which, d, 1'b1);
        @(negedge clk);
        if (!hold) set_valid(which, 1'b0);
    endtask

    // Compares tx against exp_q every cycle; counts as one comparison.
    task automatic checkStream(input int which, input string name, input int drop_k,
                               input int pulse_k, input logic [7:0] pulse_d);
        int   bad = 0, first = -1;
        logic got_f = 1'b0, exp_f = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k == drop_k) set_valid(which, 1'b0);
            if (pulse_k >= 0 && k == pulse_k) set_tx(which, pulse_d, 1'b1);
            if (pulse_k >= 0 && k == pulse_k + 1) set_valid(which, 1'b0);
            if (get_tx(which) !== exp_q[k]) begin
                if (bad == 0) begin
                    first = k;
                    got_f = get_tx(which);
                    exp_f = exp_q[k];
                end
                bad++;
            end
            @(negedge clk);
        end
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("[TB] FAIL %s: %0d of %0d cycles wrong, first at cycle %0d got %b expected %b",
                     name, bad, exp_q.size(), first, got_f, exp_f);
        end
        exp_q.delete();
    endtask

    // Drives one frame onto the selected rx line, starting at a negedge.
    task automatic injectFrame(input int which, input logic [7:0] d, input logic pbit,
                               input logic stop1, input int nstop, input logic end_level,
                               output int fall_cyc);
        fall_cyc = cyc;
        set_drv(which, 1'b0);
        repeat (BC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_drv(which, d[i]);
            repeat (BC) @(negedge clk);
        end
        set_drv(which, pbit);
        repeat (BC) @(negedge clk);
        set_drv(which, stop1);
        repeat (BC) @(negedge clk);
        for (int i = 1; i < nstop; i++) begin
            set_drv(which, 1'b1);
            repeat (BC) @(negedge clk);
        end
        set_drv(which, end_level);
    endtask

    initial begin
        int n0, bad, fall, lat, nom;
        logic [7:0] d;
        logic bad_par, bad_stop;

        rst = 1'b1;
        tx_data_a = 8'h00; tx_valid_a = 1'b0;
        tx_data_b = 8'h00; tx_valid_b = 1'b0;
        loop_a = 1'b0; loop_b = 1'b0; drv_a = 1'b1; drv_b = 1'b1;

        vecs[0] = '{8'hA5, 1'b0, 8'hA5};
        vecs[1] = '{8'h00, 1'b0, 8'h00};
        vecs[2] = '{8'hFF, 1'b0, 8'hFF};
        vecs[3] = '{8'h01, 1'b1, 8'h01};
        vecs[4] = '{8'h80, 1'b1, 8'h80};
        vecs[5] = '{8'h3C, 1'b0, 8'h3C};
        vecs[6] = '{8'h7E, 1'b0, 8'h7E};
        vecs[7] = '{8'h5B, 1'b1, 8'h5B};

        // Reset values, then idle hold with rx high.
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_tx_a", {31'd0, tx_a}, 32'd1);
        checkOutput("reset_ready_a", {31'd0, tx_ready_a}, 32'd1);
        checkOutput("reset_rx_valid_a", {31'd0, rx_valid_a}, 32'd0);
        checkOutput("reset_perr_a", {31'd0, perr_a}, 32'd0);
        checkOutput("reset_ferr_a", {31'd0, ferr_a}, 32'd0);
        checkOutput("reset_rx_data_a", {24'd0, rx_data_a}, 32'd0);
        checkOutput("reset_tx_b", {31'd0, tx_b}, 32'd1);
        checkOutput("reset_ready_b", {31'd0, tx_ready_b}, 32'd1);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 10000; i++) begin
            if (tx_a !== 1'b1 || tx_ready_a !== 1'b1 || rx_valid_a !== 1'b0 || perr_a !== 1'b0 ||
                ferr_a !== 1'b0 || tx_b !== 1'b1 || tx_ready_b !== 1'b1 || rx_valid_b !== 1'b0) bad++;
            @(negedge clk);
        end
        checkOutput("reset_idle_hold_bad_cycles", bad, 0);

        // Table-driven loopback on dut_a.
        loop_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n0 = nv_a;
            appendFrame(vecs[i].data, vecs[i].exp_par, 2);
            applyStimulus(0, vecs[i].data, 1'b0);
            checkStream(0, $sformatf("vec%0d_tx_stream", i), -1, -1, 8'h00);
            checkOutput($sformatf("vec%0d_ready_after", i), {31'd0, tx_ready_a}, 32'd1);
            repeat (2) @(negedge clk);
            checkOutput($sformatf("vec%0d_rx_count", i), nv_a - n0, 1);
            checkOutput($sformatf("vec%0d_rx_data", i), {24'd0, rx_data_a}, {24'd0, vecs[i].exp_rx});
            checkOutput($sformatf("vec%0d_flags", i), {30'd0, perr_a, ferr_a}, 32'd0);
        end

        // Odd parity: 0x00 carries parity 1; an even-parity frame is flagged.
        loop_b = 1'b1;
        n0 = nv_b;
        appendFrame(8'h00, 1'b1, 1);
        applyStimulus(1, 8'h00, 1'b0);
        checkStream(1, "odd_00_tx_stream", -1, -1, 8'h00);
        repeat (2) @(negedge clk);
        checkOutput("odd_00_rx_count", nv_b - n0, 1);
        checkOutput("odd_00_perr", {31'd0, perr_b}, 32'd0);
        drv_b = 1'b1;
        loop_b = 1'b0;
        repeat (BC) @(negedge clk);
        n0 = nv_b;
        injectFrame(1, 8'h00, 1'b0, 1'b1, 1, 1'b1, fall);
        repeat (2) @(negedge clk);
        checkOutput("even_into_odd_rx_count", nv_b - n0, 1);
        checkOutput("even_into_odd_perr", {31'd0, perr_b}, 32'd1);
        checkOutput("even_into_odd_data", {24'd0, rx_data_b}, 32'd0);
        checkOutput("even_into_odd_ferr", {31'd0, ferr_b}, 32'd0);

        // Random loopback on dut_b against the frame model.
        loop_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            n0 = nv_b;
            appendFrame(d, model_parity(d, 2), 1);
            applyStimulus(1, d, 1'b0);
            checkStream(1, $sformatf("rand_b%0d_tx_stream", i), -1, -1, 8'h00);
            repeat (2) @(negedge clk);
            checkOutput($sformatf("rand_b%0d_rx_count", i), nv_b - n0, 1);
            checkOutput($sformatf("rand_b%0d_rx_data", i), {24'd0, rx_data_b}, {24'd0, d});
            checkOutput($sformatf("rand_b%0d_flags", i), {30'd0, perr_b, ferr_b}, 32'd0);
        end

        // Framing error, then a held break must not restart reception.
        drv_a = 1'b1;
        loop_a = 1'b0;
        repeat (BC) @(negedge clk);
        n0 = nv_a;
        injectFrame(0, 8'h96, model_parity(8'h96, 1), 1'b0, 1, 1'b0, fall);
        repeat (2) @(negedge clk);
        checkOutput("frame_err_rx_count", nv_a - n0, 1);
        checkOutput("frame_err_ferr", {31'd0, ferr_a}, 32'd1);
        checkOutput("frame_err_perr", {31'd0, perr_a}, 32'd0);
        checkOutput("frame_err_data", {24'd0, rx_data_a}, 32'h96);
        n0 = nv_a;
        repeat (20000) @(negedge clk);
        checkOutput("break_no_rx_valid", nv_a - n0, 0);
        drv_a = 1'b1;
        repeat (2 * BC) @(negedge clk);

        // Glitch shorter than half a bit is rejected; a clean frame follows.
        n0 = nv_a;
        drv_a = 1'b0;
        repeat (4) @(negedge clk);
        drv_a = 1'b1;
        repeat (BC) @(negedge clk);
        checkOutput("glitch_no_rx_valid", nv_a - n0, 0);
        injectFrame(0, 8'h3C, model_parity(8'h3C, 1), 1'b1, 2, 1'b1, fall);
        repeat (2) @(negedge clk);
        checkOutput("after_glitch_rx_count", nv_a - n0, 1);
        checkOutput("after_glitch_data", {24'd0, rx_data_a}, 32'h3C);
        checkOutput("after_glitch_flags", {30'd0, perr_a, ferr_a}, 32'd0);
        lat = last_cyc_a - fall;
        nom = 2 + HALF + 10 * BC;
        compared++;
        if (lat < nom - 1 || lat > nom + 1) begin
            mismatched++;
            $display("[TB] FAIL rx_latency: got %0d cycles expected %0d +/-1", lat, nom);
        end

        // Random injected frames with random parity/stop corruption.
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            bad_par = 1'($urandom_range(0, 1));
            bad_stop = ($urandom_range(0, 3) == 0);
            n0 = nv_a;
            injectFrame(0, d, model_parity(d, 1) ^ bad_par, !bad_stop, 2, 1'b1, fall);
            repeat (2) @(negedge clk);
            checkOutput($sformatf("inj%0d_rx_count", i), nv_a - n0, 1);
            checkOutput($sformatf("inj%0d_rx_data", i), {24'd0, rx_data_a}, {24'd0, d});
            checkOutput($sformatf("inj%0d_perr", i), {31'd0, perr_a}, {31'd0, bad_par});
            checkOutput($sformatf("inj%0d_ferr", i), {31'd0, ferr_a}, {31'd0, bad_stop});
            repeat (BC) @(negedge clk);
        end

        // Back-to-back: valid held across two payloads.
        loop_a = 1'b1;
        repeat (2 * BC) @(negedge clk);
        n0 = nv_a;
        appendFrame(8'h11, model_parity(8'h11, 1), 2);
        exp_q.push_back(1'b1);
        appendFrame(8'h22, model_parity(8'h22, 1), 2);
        applyStimulus(0, 8'h11, 1'b1);
        tx_data_a = 8'h22;
        checkStream(0, "b2b_tx_stream", NA * BC + 1, -1, 8'h00);
        repeat (2) @(negedge clk);
        checkOutput("b2b_rx_count", nv_a - n0, 2);
        checkOutput("b2b_rx_data", {24'd0, rx_data_a}, 32'h22);

        // A valid pulse mid-frame must neither corrupt nor queue a frame.
        n0 = nv_a;
        appendFrame(8'h5A, model_parity(8'h5A, 1), 2);
        for (int i = 0; i < 2 * BC; i++) exp_q.push_back(1'b1);
        applyStimulus(0, 8'h5A, 1'b0);
        checkStream(0, "pulse_ignored_tx_stream", -1, 50, 8'hFF);
        checkOutput("pulse_ignored_ready", {31'd0, tx_ready_a}, 32'd1);
        checkOutput("pulse_ignored_rx_count", nv_a - n0, 1);
        checkOutput("pulse_ignored_rx_data", {24'd0, rx_data_a}, 32'h5A);

        // Reset mid-frame aborts both directions.
        n0 = nv_a;
        applyStimulus(0, 8'hC3, 1'b0);
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_tx", {31'd0, tx_a}, 32'd1);
        checkOutput("abort_ready", {31'd0, tx_ready_a}, 32'd1);
        rst = 1'b0;
        repeat (3 * NA * BC) @(negedge clk);
        checkOutput("abort_no_rx_valid", nv_a - n0, 0);
        checkOutput("abort_tx_idle", {31'd0, tx_a}, 32'd1);
        checkOutput("abort_b_ready", {31'd0, tx_ready_b}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
